// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: loader FSM states and the bus direction
// encoding used by the core, the RAM and the loader.
package boot_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERR   = 2'd3
  } boot_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/bus_mux.sv
// 2:1 selection of the RAM bus: sel=0 routes the loader registers, sel=1 the core bus.
module bus_mux #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          sel,
  input  logic          a_rw,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_rw,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          y_rw,
  output logic [AW-1:0] y_addr,
  output logic [DW-1:0] y_data
);

  assign y_rw   = sel ? b_rw   : a_rw;
  assign y_addr = sel ? b_addr : a_addr;
  assign y_data = sel ? b_data : a_data;

endmodule

// File: rtl/boot_loader.sv
// Streams a host byte image into RAM starting at LOAD_BASE, then hands the RAM bus
// to the core and raises cpu_run. An image longer than MAX_LEN parks in ERR.
module boot_loader
  import boot_pkg::*;
#(
  parameter logic [15:0] LOAD_BASE = 16'h0000,
  parameter int          MAX_LEN   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  // Host stream: a byte moves on any cycle where s_valid && s_ready are both high.
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        cpu_RW,
  input  logic [15:0] cpu_AD,
  input  logic [7:0]  cpu_D_out,
  output logic        mem_RW,
  output logic [15:0] mem_A,
  output logic [7:0]  mem_D,
  output logic        cpu_run,
  output logic [16:0] load_count,
  output logic        load_err,
  output logic [1:0]  state_dbg
);

  localparam logic [16:0] MAX_CNT = 17'(MAX_LEN);

  boot_state_t state;
  logic [15:0] addr;
  logic        ld_rw;
  logic [15:0] ld_a;
  logic [7:0]  ld_d;
  logic        accept;

  assign s_ready   = (state == ST_LOAD);
  assign accept    = s_valid && s_ready;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      addr       <= LOAD_BASE;
      load_count <= '0;
      cpu_run    <= 1'b0;
      load_err   <= 1'b0;
      ld_rw      <= RW_READ;
      ld_a       <= '0;
      ld_d       <= '0;
    end else begin
      // Default: no write this cycle; address/data hold their last values.
      ld_rw <= RW_READ;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (load_count == MAX_CNT) begin
              state    <= ST_ERR;
              load_err <= 1'b1;
            end else begin
              ld_rw      <= RW_WRITE;
              ld_a       <= addr;
              ld_d       <= s_data;
              addr       <= addr + 16'd1;
              load_count <= load_count + 17'd1;
              if (s_last) state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          state   <= ST_RUN;
          cpu_run <= 1'b1;
        end
        ST_RUN:  state <= ST_RUN;
        ST_ERR:  state <= ST_ERR;
        default: state <= ST_ERR;
      endcase
    end
  end

  bus_mux #(.AW(16), .DW(8)) u_bus_mux (
    .sel    (cpu_run),
    .a_rw   (ld_rw),
    .a_addr (ld_a),
    .a_data (ld_d),
    .b_rw   (cpu_RW),
    .b_addr (cpu_AD),
    .b_data (cpu_D_out),
    .y_rw   (mem_RW),
    .y_addr (mem_A),
    .y_data (mem_D)
  );

endmodule
